text_line_overlay: RTL and testbench
====================================

Name: text_line_overlay

Overview:
- Upstream feeder for the glyph ROM (`characters`). Holds a writable single line of ASCII characters.
- Takes the VGA pixel coordinate stream and computes, for each pixel, the character code and in-glyph coordinates (select, coor_x, coor_y) for the ROM.
- Takes back the ROM's combinational pixel bit and emits a registered, region-qualified overlay pixel with fixed latency.
- Sits between the VGA timing generator and the colour mux.

Parameters:
- MAX_CHARS, 16, number of character cells in the line (power of 2, ≥2).
- X0, 0, left edge of the text region in screen pixels.
- Y0, 0, top edge of the text region in screen pixels.
- SCALE_LOG2, 0, each font pixel is drawn as a 2^SCALE_LOG2 square.
- COORD_W, 11, width of hc/vc.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- wr_valid  in  1  character write request
- wr_ready  out  1  write accepted when wr_valid&&wr_ready at rising edge
- wr_addr  in  $clog2(MAX_CHARS)  cell index to write
- wr_char  in  8  ASCII code to store
- clear  in  1  single-cycle pulse: fill buffer with spaces
- hc  in  COORD_W  current horizontal pixel
- vc  in  COORD_W  current vertical pixel
- video_on  in  1  active-video qualifier for hc/vc
- char_select  out  8  to ROM select
- coor_x  out  3  to ROM, glyph column, 0 = leftmost
- coor_y  out  3  to ROM, glyph row, 0 = top
- font_pixel  in  1  ROM pixel for current char_select/coor_x/coor_y (combinational)
- pixel_out  out  1  overlay pixel, 1 = draw text colour

Behaviour:
- Geometry:
  - Cell is 8×8 font units; glyph occupies columns 0..4; columns 5..7 are inter-character gap.
  - rx = hc−X0, ry = vc−Y0 (unsigned, COORD_W bits).
  - in_region = video_on && hc≥X0 && hc<X0+(MAX_CHARS·8<<SCALE_LOG2) && vc≥Y0 && vc<Y0+(8<<SCALE_LOG2).
  - fu = rx>>SCALE_LOG2; idx = fu>>3; coor_x = fu[2:0]; coor_y = (ry>>SCALE_LOG2)[2:0].
- Pipeline, fixed latency 2:
  - Edge k samples hc/vc/video_on.
  - After edge k+1: char_select (synchronous buffer read of idx), coor_x, coor_y, and the registered qualifiers in_region and gap = (coor_x≥5) are valid.
  - After edge k+2: pixel_out = font_pixel && in_region && !gap && (char_select != 8'd32).
  - Outside the region, char_select = 8'd32 and coor_x = coor_y = 0, so the ROM is never indexed past column 4.
- Buffer:
  - MAX_CHARS×8 storage, synchronous read, read-first on same-address write in the same cycle (old value returned; new value appears on the next access).
  - Space (8'd32) is blanked here because the ROM does not map it.
- Control FSM, states CLEAR and IDLE:
  - rst → CLEAR with sweep address 0.
  - CLEAR: writes 8'd32 to the sweep address each cycle and increments it; wr_ready = 0; leaves for IDLE after address MAX_CHARS−1 is written. Clear sweep takes exactly MAX_CHARS cycles after rst deasserts.
  - IDLE: wr_ready = 1; a write is performed on wr_valid; clear → CLEAR with sweep address 0.
  - clear asserted while in CLEAR is ignored; the sweep is not restarted.
  - wr_valid asserted while in CLEAR is not accepted; the writer must hold the request.
  - wr_valid and clear together in IDLE: the write is performed, then CLEAR begins on the next cycle, so the written character is overwritten.
  - rst mid-sweep restarts the sweep at address 0.
- Reset values: pixel_out = 0, char_select = 8'd32, coor_x = 0, coor_y = 0, wr_ready = 0, pipeline qualifiers = 0.
- Rendering continues during CLEAR; cells not yet cleared may display stale data for at most one partial frame.
- All arithmetic is unsigned COORD_W; hc<X0 is rejected by the comparison, never by wrap of rx.

Decomposition:
- Package text_overlay_pkg holds:
  - SPACE_CHAR = 8'd32
  - CELL_W_LOG2 = 3
  - GLYPH_W = 5
  - typedef enum logic {CLEAR, IDLE} ovl_state_t
- Sub-module text_line_buffer: parameterised MAX_CHARS×8 RAM, one write port, one synchronous read-first read port.
- characters stays external, connected at the parent level.

Test Plan (MAX_CHARS=16, X0=100, Y0=50, SCALE_LOG2=1):
1. Pulse rst 1 cycle → wr_ready=0 for exactly 16 cycles, then 1; pixel_out=0 throughout; all cells read 8'd32.
2. Write addr 0 = 8'd97; drive hc=100, vc=50, video_on=1 → one cycle later char_select=97, coor_x=0, coor_y=0. hc=102 → coor_x=1. hc=110 → coor_x=5 and pixel_out=0 even with font_pixel=1.
3. Region edges:
   - hc=116 → idx 1, coor_x=0.
   - hc=99, hc=356, vc=66, or video_on=0 → pixel_out=0 and char_select=32.
   - vc=65 → coor_y=7.
4. Cell 2 = "1", cell 3 = space, font_pixel tied 1, hc swept 132..163 → pixel_out=1 exactly 2 cycles after hc=132..141; 0 for gap and cell-3 pixels.
5. Write during clear:
   - Pulse clear with wr_valid held (addr 4, 8'd65) → not accepted for 16 cycles, then accepted on the first IDLE edge; cell 4 reads 65.
   - rst at sweep address 7 → sweep restarts at 0 and lasts 16 cycles.
6. Same-cycle write to idx 5 and render read of idx 5 → char_select shows the old code; the next read of idx 5 shows the new code.

Source files
------------

// File: rtl/text_overlay_pkg.sv
// Shared constants and types for the single-line text overlay that feeds the glyph ROM.
package text_overlay_pkg;

    localparam logic [7:0] SPACE_CHAR  = 8'd32;
    localparam int         CELL_W_LOG2 = 3;
    localparam int         GLYPH_W     = 5;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } ovl_state_t;

endpackage

// File: rtl/text_line_buffer.sv
// Character line storage: one write port, one synchronous read-first read port.
// The read port returns a space whenever it is not enabled, so off-region pixels never index the ROM.
module text_line_buffer
    import text_overlay_pkg::*;
#(
    parameter int MAX_CHARS = 16,
    parameter int ADDR_W    = $clog2(MAX_CHARS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem_r [MAX_CHARS];
    logic [7:0] rdata_r;

    // Storage write port; contents are not reset, the control FSM sweeps them on reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port, read-first against a same-cycle write to the same cell.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= SPACE_CHAR;
        end else if (rd_en) begin
            rdata_r <= mem_r[raddr];
        end else begin
            rdata_r <= SPACE_CHAR;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/text_line_overlay.sv
// Single-line text overlay: maps the VGA pixel stream onto glyph ROM coordinates and
// qualifies the ROM pixel back into a registered overlay pixel, two cycles behind hc/vc.
module text_line_overlay
    import text_overlay_pkg::*;
#(
    parameter int MAX_CHARS  = 16,
    parameter int X0         = 0,
    parameter int Y0         = 0,
    parameter int SCALE_LOG2 = 0,
    parameter int COORD_W    = 11
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [$clog2(MAX_CHARS)-1:0] wr_addr,
    input  logic [7:0]                   wr_char,
    input  logic                         clear,
    input  logic [COORD_W-1:0]           hc,
    input  logic [COORD_W-1:0]           vc,
    input  logic                         video_on,
    output logic [7:0]                   char_select,
    output logic [2:0]                   coor_x,
    output logic [2:0]                   coor_y,
    input  logic                         font_pixel,
    output logic                         pixel_out
);

    localparam int ADDR_W = $clog2(MAX_CHARS);
    localparam int X_SPAN = (MAX_CHARS << CELL_W_LOG2) << SCALE_LOG2;
    localparam int Y_SPAN = (1 << CELL_W_LOG2) << SCALE_LOG2;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COORD_W:0]   coord_ext_t;

    // One spare bit keeps the right/bottom bounds from wrapping at the top of the coordinate range.
    localparam coord_ext_t X_LO = coord_ext_t'(X0);
    localparam coord_ext_t X_HI = coord_ext_t'(X0 + X_SPAN);
    localparam coord_ext_t Y_LO = coord_ext_t'(Y0);
    localparam coord_ext_t Y_HI = coord_ext_t'(Y0 + Y_SPAN);
    localparam addr_t      LAST_CELL = addr_t'(MAX_CHARS - 1);

    ovl_state_t state_r;
    addr_t      sweep_r;
    logic       wr_ready_r;

    coord_t     hc_r;
    coord_t     vc_r;
    logic       video_on_r;

    coord_t     rx_s;
    coord_t     ry_s;
    coord_t     fu_x_s;
    addr_t      idx_s;
    logic [2:0] coor_x_s;
    logic [2:0] coor_y_s;
    logic       in_region_s;
    logic       gap_s;

    logic [2:0] coor_x_r;
    logic [2:0] coor_y_r;
    logic       in_region_r;
    logic       gap_r;
    logic       pixel_r;

    logic       buf_we_s;
    addr_t      buf_waddr_s;
    logic [7:0] buf_wdata_s;
    logic [7:0] buf_rdata_s;

    // Control FSM: reset and clear sweep every cell to space before accepting writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= CLEAR;
            sweep_r    <= '0;
            wr_ready_r <= 1'b0;
        end else begin
            case (state_r)
                CLEAR: begin
                    sweep_r <= sweep_r + addr_t'(1'b1);
                    if (sweep_r == LAST_CELL) begin
                        state_r    <= IDLE;
                        wr_ready_r <= 1'b1;
                    end else begin
                        state_r    <= CLEAR;
                        wr_ready_r <= 1'b0;
                    end
                end
                IDLE: begin
                    if (clear) begin
                        state_r    <= CLEAR;
                        sweep_r    <= '0;
                        wr_ready_r <= 1'b0;
                    end else begin
                        state_r    <= IDLE;
                        wr_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= CLEAR;
                    sweep_r    <= '0;
                    wr_ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Buffer write source: sweep during CLEAR, host writes in IDLE.
    always_comb begin
        buf_we_s    = 1'b0;
        buf_waddr_s = '0;
        buf_wdata_s = SPACE_CHAR;
        case (state_r)
            CLEAR: begin
                buf_we_s    = 1'b1;
                buf_waddr_s = sweep_r;
                buf_wdata_s = SPACE_CHAR;
            end
            IDLE: begin
                buf_we_s    = wr_valid;
                buf_waddr_s = wr_addr;
                buf_wdata_s = wr_char;
            end
            default: begin
                buf_we_s    = 1'b0;
                buf_waddr_s = '0;
                buf_wdata_s = SPACE_CHAR;
            end
        endcase
    end

    // Stage 0: sample the incoming pixel coordinate.
    always_ff @(posedge clk) begin
        if (rst) begin
            hc_r       <= '0;
            vc_r       <= '0;
            video_on_r <= 1'b0;
        end else begin
            hc_r       <= hc;
            vc_r       <= vc;
            video_on_r <= video_on;
        end
    end

    // Region test and font-unit position of the sampled pixel.
    always_comb begin
        rx_s     = hc_r - coord_t'(X0);
        ry_s     = vc_r - coord_t'(Y0);
        fu_x_s   = rx_s >> SCALE_LOG2;
        idx_s    = addr_t'(fu_x_s >> CELL_W_LOG2);
        coor_x_s = 3'(fu_x_s);
        coor_y_s = 3'(ry_s >> SCALE_LOG2);
        gap_s    = (coor_x_s >= 3'(GLYPH_W));
        if (video_on_r
            && ({1'b0, hc_r} >= X_LO) && ({1'b0, hc_r} < X_HI)
            && ({1'b0, vc_r} >= Y_LO) && ({1'b0, vc_r} < Y_HI)) begin
            in_region_s = 1'b1;
        end else begin
            in_region_s = 1'b0;
        end
    end

    // Stage 1: ROM coordinates and qualifiers, forced to column/row 0 outside the text region.
    always_ff @(posedge clk) begin
        if (rst) begin
            coor_x_r    <= 3'd0;
            coor_y_r    <= 3'd0;
            in_region_r <= 1'b0;
            gap_r       <= 1'b0;
        end else if (in_region_s) begin
            coor_x_r    <= coor_x_s;
            coor_y_r    <= coor_y_s;
            in_region_r <= 1'b1;
            gap_r       <= gap_s;
        end else begin
            coor_x_r    <= 3'd0;
            coor_y_r    <= 3'd0;
            in_region_r <= 1'b0;
            gap_r       <= 1'b0;
        end
    end

    text_line_buffer #(
        .MAX_CHARS (MAX_CHARS),
        .ADDR_W    (ADDR_W)
    ) u_buffer (
        .clk   (clk),
        .rst   (rst),
        .we    (buf_we_s),
        .waddr (buf_waddr_s),
        .wdata (buf_wdata_s),
        .rd_en (in_region_s),
        .raddr (idx_s),
        .rdata (buf_rdata_s)
    );

    // Stage 2: the ROM bit is shown only for glyph columns of non-space cells; space is not in the ROM.
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_r <= 1'b0;
        end else begin
            pixel_r <= font_pixel && in_region_r && !gap_r && (buf_rdata_s != SPACE_CHAR);
        end
    end

    assign wr_ready    = wr_ready_r;
    assign char_select = buf_rdata_s;
    assign coor_x      = coor_x_r;
    assign coor_y      = coor_y_r;
    assign pixel_out   = pixel_r;

endmodule

// File: tb/tb_text_line_overlay.sv
// Bench for text_line_overlay: directed scenarios plus a randomized stream against a
// geometric reference model; the glyph ROM is stood in for by a fixed hash or a constant 1.
module tb_text_line_overlay;

    localparam int MAX_CHARS  = 16;
    localparam int X0         = 100;
    localparam int Y0         = 50;
    localparam int SCALE_LOG2 = 1;
    localparam int COORD_W    = 11;
    localparam int SC         = 1 << SCALE_LOG2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [3:0]  wr_addr = 4'd0;
    logic [7:0]  wr_char = 8'd0;
    logic        clear = 1'b0;
    logic [10:0] hc = 11'd0;
    logic [10:0] vc = 11'd0;
    logic        video_on = 1'b0;
    logic [7:0]  char_select;
    logic [2:0]  coor_x;
    logic [2:0]  coor_y;
    logic        font_pixel;
    logic        pixel_out;
    logic        rom_hash = 1'b0;

    int total = 0;
    int bad   = 0;
    logic [7:0] model [MAX_CHARS];

    always #5 clk = ~clk;

    function automatic logic rom_fn(input logic [7:0] c, input logic [2:0] x, input logic [2:0] y);
        logic [13:0] v;
        v = {c, x, y};
        return ^(v & 14'h1ad3);
    endfunction

    assign font_pixel = rom_hash ? rom_fn(char_select, coor_x, coor_y) : 1'b1;

    text_line_overlay #(
        .MAX_CHARS (MAX_CHARS), .X0 (X0), .Y0 (Y0),
        .SCALE_LOG2 (SCALE_LOG2), .COORD_W (COORD_W)
    ) dut (
        .clk (clk), .rst (rst), .wr_valid (wr_valid), .wr_ready (wr_ready),
        .wr_addr (wr_addr), .wr_char (wr_char), .clear (clear),
        .hc (hc), .vc (vc), .video_on (video_on),
        .char_select (char_select), .coor_x (coor_x), .coor_y (coor_y),
        .font_pixel (font_pixel), .pixel_out (pixel_out)
    );

    // Reference geometry straight from screen arithmetic.
    function automatic void ref_geom(input int h, input int v, input bit vo,
                                     output bit inr, output int idx, output int x, output int y);
        inr = vo && h >= X0 && h < X0 + MAX_CHARS * 8 * SC && v >= Y0 && v < Y0 + 8 * SC;
        if (inr) begin
            idx = ((h - X0) / SC) / 8;
            x   = ((h - X0) / SC) % 8;
            y   = ((v - Y0) / SC) % 8;
        end else begin
            idx = 0; x = 0; y = 0;
        end
    endfunction

    task automatic probe(input int h, input int v, input bit vo,
                         output logic [7:0] sel, output logic [2:0] x, output logic [2:0] y,
                         output logic pix);
        hc = h[10:0]; vc = v[10:0]; video_on = vo;
        @(posedge clk); @(posedge clk); #1;
        sel = char_select; x = coor_x; y = coor_y;
        @(posedge clk); #1;
        pix = pixel_out;
    endtask

    task automatic write_char(input int a, input logic [7:0] c);
        total++;
        if (wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL write_ready addr=%0d got=%b want=1", a, wr_ready);
        end
        wr_addr = a[3:0]; wr_char = c; wr_valid = 1'b1;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        model[a] = c;
    endtask

    // Called right after the edge that sampled rst high (or a clear pulse): 16 busy cycles, then ready.
    task automatic check_sweep(input string name);
        for (int i = 0; i < MAX_CHARS; i++) begin
            total++;
            if (wr_ready !== 1'b0 || pixel_out !== 1'b0) begin
                bad++;
                $display("FAIL %s_busy cyc=%0d wr_ready=%b pixel=%b want 0/0", name, i, wr_ready, pixel_out);
            end
            @(posedge clk); #1;
        end
        total++;
        if (wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_ready got=%b want=1", name, wr_ready);
        end
        for (int i = 0; i < MAX_CHARS; i++) model[i] = 8'd32;
    endtask

    task automatic test_reset;
        logic [7:0] s; logic [2:0] x, y; logic p;
        video_on = 1'b0;
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        total++;
        if (char_select !== 8'd32 || coor_x !== 3'd0 || coor_y !== 3'd0 || pixel_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_values sel=%0d x=%0d y=%0d pix=%b want 32/0/0/0",
                     char_select, coor_x, coor_y, pixel_out);
        end
        check_sweep("reset");
        rom_hash = 1'b0;
        for (int i = 0; i < MAX_CHARS; i++) begin
            probe(X0 + i * 16, Y0, 1'b1, s, x, y, p);
            total++;
            if (s !== 8'd32 || p !== 1'b0) begin
                bad++;
                $display("FAIL reset_cell%0d sel=%0d pix=%b want 32/0", i, s, p);
            end
        end
    endtask

    task automatic test_basic;
        logic [7:0] s; logic [2:0] x, y; logic p;
        rom_hash = 1'b0;
        write_char(0, 8'd97);
        probe(100, 50, 1'b1, s, x, y, p);
        total++;
        if (s !== 8'd97 || x !== 3'd0 || y !== 3'd0 || p !== 1'b1) begin
            bad++;
            $display("FAIL basic_origin sel=%0d x=%0d y=%0d pix=%b want 97/0/0/1", s, x, y, p);
        end
        probe(102, 50, 1'b1, s, x, y, p);
        total++;
        if (s !== 8'd97 || x !== 3'd1) begin
            bad++;
            $display("FAIL basic_col1 sel=%0d x=%0d want 97/1", s, x);
        end
        probe(110, 50, 1'b1, s, x, y, p);
        total++;
        if (x !== 3'd5 || p !== 1'b0) begin
            bad++;
            $display("FAIL basic_gap x=%0d pix=%b want 5/0", x, p);
        end
    endtask

    task automatic test_edges;
        logic [7:0] s; logic [2:0] x, y; logic p;
        int hs [4] = '{99, 356, 100, 100};
        int vs [4] = '{50, 50, 66, 50};
        bit os [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        rom_hash = 1'b0;
        write_char(1, 8'd98);
        probe(116, 50, 1'b1, s, x, y, p);
        total++;
        if (s !== 8'd98 || x !== 3'd0) begin
            bad++;
            $display("FAIL edge_cell1 sel=%0d x=%0d want 98/0", s, x);
        end
        for (int i = 0; i < 4; i++) begin
            probe(hs[i], vs[i], os[i], s, x, y, p);
            total++;
            if (s !== 8'd32 || x !== 3'd0 || y !== 3'd0 || p !== 1'b0) begin
                bad++;
                $display("FAIL edge_outside hc=%0d vc=%0d vo=%b sel=%0d x=%0d y=%0d pix=%b want 32/0/0/0",
                         hs[i], vs[i], os[i], s, x, y, p);
            end
        end
        probe(100, 65, 1'b1, s, x, y, p);
        total++;
        if (s !== 8'd97 || y !== 3'd7) begin
            bad++;
            $display("FAIL edge_bottom sel=%0d y=%0d want 97/7", s, y);
        end
    endtask

    task automatic test_sweep_row;
        int h; logic e;
        rom_hash = 1'b0;
        write_char(2, 8'd49);
        write_char(3, 8'd32);
        vc = 11'd50; video_on = 1'b1;
        for (int i = 0; i < 34; i++) begin
            if (i < 32) hc = 11'(132 + i);
            @(posedge clk); #1;
            if (i >= 2) begin
                h = 132 + i - 2;
                e = (h <= 141);
                total++;
                if (pixel_out !== e) begin
                    bad++;
                    $display("FAIL row_pixel hc=%0d got=%b want=%b", h, pixel_out, e);
                end
            end
        end
    endtask

    task automatic test_write_during_clear;
        logic [7:0] s; logic [2:0] x, y; logic p;
        video_on = 1'b0;
        clear = 1'b1; @(posedge clk); #1; clear = 1'b0;
        wr_addr = 4'd4; wr_char = 8'd65; wr_valid = 1'b1;
        check_sweep("clear");
        @(posedge clk); #1;
        wr_valid = 1'b0;
        model[4] = 8'd65;
        probe(X0 + 4 * 16, Y0, 1'b1, s, x, y, p);
        total++;
        if (s !== 8'd65) begin
            bad++;
            $display("FAIL clear_held_write sel=%0d want=65", s);
        end
        video_on = 1'b0;
        clear = 1'b1; @(posedge clk); #1; clear = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        total++;
        if (wr_ready !== 1'b0) begin
            bad++;
            $display("FAIL midsweep_busy got=%b want=0", wr_ready);
        end
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        check_sweep("rst_midsweep");
    endtask

    task automatic test_back_to_back;
        write_char(5, 8'd65);
        hc = 11'(X0 + 80); vc = 11'(Y0); video_on = 1'b1;
        @(posedge clk); #1;
        wr_addr = 4'd5; wr_char = 8'd90; wr_valid = 1'b1;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        model[5] = 8'd90;
        total++;
        if (char_select !== 8'd65) begin
            bad++;
            $display("FAIL same_cycle_old sel=%0d want=65", char_select);
        end
        @(posedge clk); #1;
        total++;
        if (char_select !== 8'd90) begin
            bad++;
            $display("FAIL same_cycle_new sel=%0d want=90", char_select);
        end
    endtask

    task automatic test_random;
        localparam int N = 400;
        logic [7:0] es [N];
        logic [2:0] ex [N];
        logic [2:0] ey [N];
        logic       ep [N];
        bit inr; int idx, x, y, h, v, a; bit vo, wr; logic [7:0] c;
        rom_hash = 1'b1;
        for (int k = 0; k < N + 2; k++) begin
            if (k < N) begin
                h  = $urandom_range(90, 370);
                v  = $urandom_range(44, 70);
                vo = ($urandom_range(0, 7) != 0);
                wr = ($urandom_range(0, 3) == 0);
                a  = $urandom_range(0, MAX_CHARS - 1);
                c  = ($urandom_range(0, 3) == 0) ? 8'd32 : 8'($urandom_range(33, 126));
                hc = h[10:0]; vc = v[10:0]; video_on = vo;
                wr_valid = wr; wr_addr = a[3:0]; wr_char = c;
                if (wr) model[a] = c;
                ref_geom(h, v, vo, inr, idx, x, y);
                es[k] = inr ? model[idx] : 8'd32;
                ex[k] = 3'(x);
                ey[k] = 3'(y);
                ep[k] = inr && (x < 5) && (es[k] != 8'd32) && rom_fn(es[k], 3'(x), 3'(y));
            end else begin
                video_on = 1'b0; wr_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (k >= 1 && k - 1 < N) begin
                total++;
                if (char_select !== es[k-1] || coor_x !== ex[k-1] || coor_y !== ey[k-1]) begin
                    bad++;
                    $display("FAIL rand_rom_coord n=%0d sel=%0d x=%0d y=%0d want %0d/%0d/%0d",
                             k - 1, char_select, coor_x, coor_y, es[k-1], ex[k-1], ey[k-1]);
                end
            end
            if (k >= 2) begin
                total++;
                if (pixel_out !== ep[k-2]) begin
                    bad++;
                    $display("FAIL rand_pixel n=%0d got=%b want=%b", k - 2, pixel_out, ep[k-2]);
                end
            end
        end
        wr_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < MAX_CHARS; i++) model[i] = 8'd0;
        @(negedge clk);
        test_reset;
        test_basic;
        test_edges;
        test_sweep_row;
        test_write_during_clear;
        test_back_to_back;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
